// File: rtl/t05_codebook_walker.sv
// Huffman codebook walker: depth-first traversal of an external node store,
// emitting one (symbol, code, length) record per leaf on a valid/ready stream.
module t05_codebook_walker #(
   parameter int IDX_W   = 7,
   parameter int SYM_W   = 8,
   parameter int SUM_W   = 46,
   parameter int MAX_LEN = 32,
   localparam int CHILD_W = 1 + SYM_W,
   localparam int NODE_W  = 2*CHILD_W + SUM_W,
   localparam int LEN_W   = $clog2(MAX_LEN+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CHILD_W-1:0] root_child,
   input  logic [IDX_W-1:0]   max_index,
   output logic               node_req,
   output logic [IDX_W-1:0]   node_addr,
   input  logic               node_valid,
   input  logic [NODE_W-1:0]  node_rdata,
   output logic               cw_valid,
   input  logic               cw_ready,
   output logic [SYM_W-1:0]   cw_symbol,
   output logic [MAX_LEN-1:0] cw_code,
   output logic [LEN_W-1:0]   cw_len,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int SP_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int STK_W = CHILD_W + LEN_W;
   localparam logic [LEN_W:0] LEN_LIM = (LEN_W+1)'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_LEFT, S_RIGHT, S_POP, S_EMIT, S_DONE
   } state_t;

   state_t             state_q, state_d, ret_q, ret_d;
   logic [IDX_W-1:0]   max_q, max_d, addr_q, addr_d;
   logic [CHILD_W-1:0] left_q, left_d, right_q, right_d;
   logic [MAX_LEN-1:0] code_q, code_d, cwc_q, cwc_d;
   logic [LEN_W-1:0]   len_q, len_d, cwl_q, cwl_d, sp_q, sp_d;
   logic [SYM_W-1:0]   sym_q, sym_d;
   logic               err_q, err_d;
   logic [STK_W-1:0]   stack_q [MAX_LEN];

   logic [CHILD_W-1:0] ch;
   logic               ch_bit;
   logic [LEN_W:0]     len_inc;
   logic [LEN_W-1:0]   sp_m1;
   logic [STK_W-1:0]   top;
   logic               push;
   logic               unused_sum;

   // LEFT and RIGHT share one datapath: the child under inspection and the code bit it adds
   assign ch         = (state_q == S_LEFT) ? left_q : right_q;
   assign ch_bit     = (state_q == S_RIGHT);
   assign len_inc    = {1'b0, len_q} + (LEN_W+1)'(1);
   assign sp_m1      = sp_q - LEN_W'(1);
   assign top        = stack_q[sp_m1[SP_W-1:0]];
   assign unused_sum = ^node_rdata[SUM_W-1:0];

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      max_d   = max_q;
      addr_d  = addr_q;
      left_d  = left_q;
      right_d = right_q;
      code_d  = code_q;
      len_d   = len_q;
      sp_d    = sp_q;
      sym_d   = sym_q;
      cwc_d   = cwc_q;
      cwl_d   = cwl_q;
      err_d   = err_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d  = 1'b0;
               code_d = '0;
               len_d  = '0;
               sp_d   = '0;
               max_d  = max_index;
               if (root_child[CHILD_W-1]) begin
                  if (root_child[IDX_W-1:0] > max_index) begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     addr_d  = root_child[IDX_W-1:0];
                     state_d = S_FETCH;
                  end
               end else begin
                  sym_d   = root_child[SYM_W-1:0];
                  cwc_d   = '0;
                  cwl_d   = LEN_W'(1);
                  ret_d   = S_DONE;
                  state_d = S_EMIT;
               end
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (node_valid) begin
               left_d  = node_rdata[NODE_W-1 -: CHILD_W];
               right_d = node_rdata[NODE_W-CHILD_W-1 -: CHILD_W];
               state_d = S_LEFT;
            end
         end
         S_LEFT, S_RIGHT: begin
            if ((len_inc > LEN_LIM) || (ch[CHILD_W-1] && (ch[IDX_W-1:0] > max_q))) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (ch[CHILD_W-1]) begin
               // only a left descent leaves a sibling behind to revisit
               if (!ch_bit) begin
                  push = 1'b1;
                  sp_d = sp_q + LEN_W'(1);
               end
               code_d  = {code_q[MAX_LEN-2:0], ch_bit};
               len_d   = len_inc[LEN_W-1:0];
               addr_d  = ch[IDX_W-1:0];
               state_d = S_FETCH;
            end else begin
               sym_d   = ch[SYM_W-1:0];
               cwc_d   = {code_q[MAX_LEN-2:0], ch_bit};
               cwl_d   = len_inc[LEN_W-1:0];
               ret_d   = ch_bit ? S_POP : S_RIGHT;
               state_d = S_EMIT;
            end
         end
         S_POP: begin
            if (sp_q == '0) begin
               state_d = S_DONE;
            end else begin
               sp_d    = sp_m1;
               code_d  = code_q >> (len_q - top[LEN_W-1:0]);
               len_d   = top[LEN_W-1:0];
               right_d = top[STK_W-1 -: CHILD_W];
               state_d = S_RIGHT;
            end
         end
         S_EMIT: if (cw_ready) state_d = ret_q;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         max_q   <= '0;
         addr_q  <= '0;
         left_q  <= '0;
         right_q <= '0;
         code_q  <= '0;
         len_q   <= '0;
         sp_q    <= '0;
         sym_q   <= '0;
         cwc_q   <= '0;
         cwl_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         max_q   <= max_d;
         addr_q  <= addr_d;
         left_q  <= left_d;
         right_q <= right_d;
         code_q  <= code_d;
         len_q   <= len_d;
         sp_q    <= sp_d;
         sym_q   <= sym_d;
         cwc_q   <= cwc_d;
         cwl_q   <= cwl_d;
         err_q   <= err_d;
      end
   end

   // Stack contents need no reset; sp_q alone defines which entries are live
   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q[SP_W-1:0]] <= {right_q, len_q};
   end

   assign node_req  = (state_q == S_FETCH);
   assign node_addr = addr_q;
   assign cw_valid  = (state_q == S_EMIT);
   assign cw_symbol = sym_q;
   assign cw_code   = cwc_q;
   assign cw_len    = cwl_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_t05_codebook_walker.sv
// Directed bench for t05_codebook_walker: a 10-leaf tree walked under varying
// node latency, backpressure, error cases, mid-walk reset and re-start attempts.
module tb_t05_codebook_walker;

   localparam int IDX_W = 7, CHILD_W = 9, NODE_W = 64;

   logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
   logic [CHILD_W-1:0] root_child = '0;
   logic [IDX_W-1:0]   max_index = '0;
   logic               node_valid = 1'b0;
   logic [NODE_W-1:0]  node_rdata = '0;
   logic               cw_ready = 1'b1;

   logic req_a, cwv_a, busy_a, done_a, err_a;
   logic [IDX_W-1:0] addr_a;
   logic [7:0] sym_a;
   logic [31:0] code_a;
   logic [5:0] len_a;

   logic req_b, cwv_b, busy_b, done_b, err_b;
   logic [IDX_W-1:0] addr_b;
   logic [7:0] sym_b;
   logic [2:0] code_b;
   logic [1:0] len_b;

   t05_codebook_walker dut (
      .clk(clk), .rst(rst), .start(start_a), .root_child(root_child), .max_index(max_index),
      .node_req(req_a), .node_addr(addr_a), .node_valid(node_valid), .node_rdata(node_rdata),
      .cw_valid(cwv_a), .cw_ready(cw_ready), .cw_symbol(sym_a), .cw_code(code_a), .cw_len(len_a),
      .busy(busy_a), .done(done_a), .err(err_a));

   t05_codebook_walker #(.MAX_LEN(3)) dut3 (
      .clk(clk), .rst(rst), .start(start_b), .root_child(root_child), .max_index(max_index),
      .node_req(req_b), .node_addr(addr_b), .node_valid(node_valid), .node_rdata(node_rdata),
      .cw_valid(cwv_b), .cw_ready(cw_ready), .cw_symbol(sym_b), .cw_code(code_b), .cw_len(len_b),
      .busy(busy_b), .done(done_b), .err(err_b));

   always #5 clk = ~clk;

   logic sel = 1'b0;
   logic req_m, cwv_m, busy_m, done_m, err_m;
   logic [IDX_W-1:0] addr_m;
   logic [7:0] sym_m;
   logic [31:0] code_m;
   logic [5:0] len_m;
   assign req_m  = sel ? req_b  : req_a;
   assign cwv_m  = sel ? cwv_b  : cwv_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign done_m = sel ? done_b : done_a;
   assign err_m  = sel ? err_b  : err_a;
   assign addr_m = sel ? addr_b : addr_a;
   assign sym_m  = sel ? sym_b  : sym_a;
   assign code_m = sel ? {29'd0, code_b} : code_a;
   assign len_m  = sel ? {4'd0, len_b} : len_a;

   localparam int EXP_SYM  [10] = '{67, 66, 65, 70, 68, 69, 74, 71, 72, 73};
   localparam int EXP_CODE [10] = '{0, 1, 1, 2, 6, 7, 2, 6, 14, 15};
   localparam int EXP_LEN  [10] = '{4, 4, 3, 3, 4, 4, 2, 3, 4, 4};

   logic [NODE_W-1:0] mem [0:127];
   int checks = 0, failures = 0;
   int lat = 1;
   logic bp_mode = 1'b0;

   // node store: node_valid pulses lat cycles after the request cycle
   int pend = 0, req_n = 0, overlap_n = 0, addr_bad_n = 0;
   logic [IDX_W-1:0] paddr = '0;
   always @(negedge clk) begin
      node_valid = 1'b0;
      if (rst) pend = 0;
      else begin
         if (pend > 0 && addr_m !== paddr) addr_bad_n++;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               node_valid = 1'b1;
               node_rdata = mem[paddr];
            end
         end
         if (req_m === 1'b1) begin
            if (pend > 0) overlap_n++;
            req_n++;
            pend = lat;
            paddr = addr_m;
         end
      end
   end

   // consumer: records transfers, stalls symbol 66 for 5 cycles when bp_mode is set
   int rec_n = 0, done_n = 0, bp_held = 0, bp_bad = 0;
   logic [7:0] rec_sym [0:255];
   logic [31:0] rec_code [0:255];
   logic [5:0] rec_len [0:255];
   logic [7:0] bp_sym = '0;
   logic [31:0] bp_code = '0;
   logic [5:0] bp_len = '0;
   always @(negedge clk) begin
      cw_ready = 1'b1;
      if (!bp_mode) bp_held = 0;
      else if (cwv_m === 1'b1 && sym_m == 8'd66) begin
         if (bp_held == 0) begin
            bp_sym = sym_m; bp_code = code_m; bp_len = len_m;
         end else if (sym_m !== bp_sym || code_m !== bp_code || len_m !== bp_len) bp_bad++;
         if (bp_held < 5) begin
            bp_held++;
            cw_ready = 1'b0;
         end
      end
      if (!rst && cwv_m === 1'b1 && cw_ready) begin
         rec_sym[rec_n] = sym_m; rec_code[rec_n] = code_m; rec_len[rec_n] = len_m;
         rec_n++;
      end
      if (done_m === 1'b1) done_n++;
   end

   function automatic logic [NODE_W-1:0] mk(input bit ln, input int lv, input bit rn, input int rv, input int s);
      logic [7:0] l8, r8;
      l8 = lv[7:0];
      r8 = rv[7:0];
      return {ln, l8, rn, r8, 46'(s)};
   endfunction

   task automatic init_mem();
      mem[0] = mk(0, 67, 0, 66, 11);
      mem[1] = mk(0, 68, 0, 69, 12);
      mem[2] = mk(0, 72, 0, 73, 13);
      mem[3] = mk(1, 0, 0, 65, 14);
      mem[4] = mk(0, 70, 1, 1, 15);
      mem[5] = mk(0, 71, 1, 2, 16);
      mem[6] = mk(1, 3, 1, 4, 17);
      mem[7] = mk(0, 74, 1, 5, 18);
      mem[8] = mk(1, 6, 1, 7, 19);
   endtask

   task automatic pulse_start(input bit b);
      @(posedge clk); #1;
      if (b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok = 1'b0;
      while (cyc < budget && !ok) begin
         @(negedge clk);
         cyc++;
         if (done_m === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin failures++; $display("FAIL reset_status: busy=%b done=%b err=%b expected 0 0 0", busy_a, done_a, err_a); end
      checks++; if (req_a !== 1'b0 || addr_a !== '0) begin failures++; $display("FAIL reset_fetch: req=%b addr=%0d expected 0 0", req_a, addr_a); end
      checks++; if (cwv_a !== 1'b0 || sym_a !== '0 || code_a !== '0 || len_a !== '0) begin failures++; $display("FAIL reset_cw: v=%b sym=%0d code=%0h len=%0d expected all 0", cwv_a, sym_a, code_a, len_a); end
      checks++; if (err_b !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_dut3: err=%b busy=%b expected 0 0", err_b, busy_b); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_base_walk();
      int b, r0, o0, cyc;
      bit ok;
      lat = 1; root_child = {1'b1, 8'd8}; max_index = 7'd8;
      b = rec_n; r0 = req_n; o0 = overlap_n;
      pulse_start(0);
      @(negedge clk);
      checks++; if (req_a !== 1'b1 || addr_a !== 7'd8) begin failures++; $display("FAIL base_first_fetch: req=%b addr=%0d expected 1 8", req_a, addr_a); end
      wait_done(59, cyc, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL base_latency: done missing after %0d cycles, expected within 60", cyc); end
      checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL base_err: err=%b expected 0", err_a); end
      checks++; if (rec_n - b !== 10) begin failures++; $display("FAIL base_count: got %0d records expected 10", rec_n - b); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({24'd0, rec_sym[b+i]} !== EXP_SYM[i] || rec_code[b+i] !== EXP_CODE[i] || {26'd0, rec_len[b+i]} !== EXP_LEN[i]) begin
            failures++;
            $display("FAIL base_rec%0d: got %0d/%0h/%0d expected %0d/%0h/%0d", i, rec_sym[b+i], rec_code[b+i], rec_len[b+i], EXP_SYM[i], EXP_CODE[i], EXP_LEN[i]);
         end
      end
      checks++; if (req_n - r0 !== 9 || overlap_n - o0 !== 0) begin failures++; $display("FAIL base_fetches: got %0d reqs %0d overlaps expected 9 0", req_n - r0, overlap_n - o0); end
   endtask

   task automatic test_slow_fetch();
      int b, o0, a0, cyc;
      bit ok;
      lat = 3; root_child = {1'b1, 8'd8}; max_index = 7'd8;
      b = rec_n; o0 = overlap_n; a0 = addr_bad_n;
      pulse_start(0);
      wait_done(200, cyc, ok);
      checks++; if (ok !== 1'b1 || err_a !== 1'b0) begin failures++; $display("FAIL slow_done: done=%b err=%b expected 1 0", ok, err_a); end
      checks++; if (rec_n - b !== 10) begin failures++; $display("FAIL slow_count: got %0d records expected 10", rec_n - b); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({24'd0, rec_sym[b+i]} !== EXP_SYM[i] || rec_code[b+i] !== EXP_CODE[i] || {26'd0, rec_len[b+i]} !== EXP_LEN[i]) begin
            failures++;
            $display("FAIL slow_rec%0d: got %0d/%0h/%0d expected %0d/%0h/%0d", i, rec_sym[b+i], rec_code[b+i], rec_len[b+i], EXP_SYM[i], EXP_CODE[i], EXP_LEN[i]);
         end
      end
      checks++; if (addr_bad_n - a0 !== 0) begin failures++; $display("FAIL slow_addr_stable: got %0d unstable cycles expected 0", addr_bad_n - a0); end
      checks++; if (overlap_n - o0 !== 0) begin failures++; $display("FAIL slow_overlap: got %0d extra reqs expected 0", overlap_n - o0); end
      lat = 1;
   endtask

   task automatic test_backpressure();
      int b, s0, cyc;
      bit ok;
      lat = 1; root_child = {1'b1, 8'd8}; max_index = 7'd8;
      b = rec_n; s0 = bp_bad;
      bp_mode = 1'b1;
      pulse_start(0);
      wait_done(120, cyc, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_done: done not seen after %0d cycles", cyc); end
      checks++; if (bp_held !== 5) begin failures++; $display("FAIL bp_stall_cycles: got %0d expected 5", bp_held); end
      checks++; if (bp_bad - s0 !== 0 || bp_sym !== 8'd66 || bp_code !== 32'h1 || bp_len !== 6'd4) begin failures++; $display("FAIL bp_hold: %0d changes, held %0d/%0h/%0d expected 0 changes 66/1/4", bp_bad - s0, bp_sym, bp_code, bp_len); end
      checks++; if (rec_n - b !== 10) begin failures++; $display("FAIL bp_count: got %0d records expected 10", rec_n - b); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({24'd0, rec_sym[b+i]} !== EXP_SYM[i] || rec_code[b+i] !== EXP_CODE[i] || {26'd0, rec_len[b+i]} !== EXP_LEN[i]) begin
            failures++;
            $display("FAIL bp_rec%0d: got %0d/%0h/%0d expected %0d/%0h/%0d", i, rec_sym[b+i], rec_code[b+i], rec_len[b+i], EXP_SYM[i], EXP_CODE[i], EXP_LEN[i]);
         end
      end
      bp_mode = 1'b0;
   endtask

   task automatic test_root_leaf();
      int b, r0, cyc;
      bit ok;
      root_child = {1'b0, 8'd90}; max_index = 7'd8;
      b = rec_n; r0 = req_n;
      pulse_start(0);
      wait_done(10, cyc, ok);
      checks++; if (ok !== 1'b1 || err_a !== 1'b0) begin failures++; $display("FAIL leaf_done: done=%b err=%b expected 1 0", ok, err_a); end
      checks++; if (rec_n - b !== 1) begin failures++; $display("FAIL leaf_count: got %0d records expected 1", rec_n - b); end
      checks++; if (rec_sym[b] !== 8'd90 || rec_code[b] !== 32'd0 || rec_len[b] !== 6'd1) begin failures++; $display("FAIL leaf_rec: got %0d/%0h/%0d expected 90/0/1", rec_sym[b], rec_code[b], rec_len[b]); end
      checks++; if (req_n - r0 !== 0) begin failures++; $display("FAIL leaf_no_fetch: got %0d reqs expected 0", req_n - r0); end
   endtask

   task automatic test_maxlen();
      int b, cyc;
      bit ok;
      sel = 1'b1; lat = 1; root_child = {1'b1, 8'd8}; max_index = 7'd8;
      b = rec_n;
      pulse_start(1);
      wait_done(100, cyc, ok);
      checks++; if (ok !== 1'b1 || err_m !== 1'b1) begin failures++; $display("FAIL maxlen_err: done=%b err=%b expected 1 1", ok, err_m); end
      checks++; if (rec_n - b !== 0) begin failures++; $display("FAIL maxlen_records: got %0d records expected 0", rec_n - b); end
      pulse_start(1);
      @(negedge clk);
      checks++; if (err_m !== 1'b0 || busy_m !== 1'b1) begin failures++; $display("FAIL maxlen_restart: err=%b busy=%b expected 0 1", err_m, busy_m); end
      wait_done(100, cyc, ok);
      checks++; if (ok !== 1'b1 || err_m !== 1'b1) begin failures++; $display("FAIL maxlen_err2: done=%b err=%b expected 1 1", ok, err_m); end
      sel = 1'b0;
   endtask

   task automatic test_bad_index();
      int b, cyc;
      bit ok;
      mem[3] = mk(1, 12, 0, 65, 14);
      root_child = {1'b1, 8'd8}; max_index = 7'd8;
      b = rec_n;
      pulse_start(0);
      wait_done(100, cyc, ok);
      checks++; if (ok !== 1'b1 || err_a !== 1'b1) begin failures++; $display("FAIL badidx_err: done=%b err=%b expected 1 1", ok, err_a); end
      checks++; if (rec_n - b !== 0) begin failures++; $display("FAIL badidx_records: got %0d records expected 0", rec_n - b); end
      init_mem();
   endtask

   task automatic test_reset_mid();
      root_child = {1'b1, 8'd8}; max_index = 7'd8;
      pulse_start(0);
      repeat (12) @(negedge clk);
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: busy=%b expected 1", busy_a); end
      rst = 1'b1;
      #1;
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || req_a !== 1'b0 || addr_a !== '0) begin failures++; $display("FAIL rstmid_ctrl: busy=%b done=%b err=%b req=%b addr=%0d expected all 0", busy_a, done_a, err_a, req_a, addr_a); end
      checks++; if (cwv_a !== 1'b0 || sym_a !== '0 || code_a !== '0 || len_a !== '0) begin failures++; $display("FAIL rstmid_cw: v=%b sym=%0d code=%0h len=%0d expected all 0", cwv_a, sym_a, code_a, len_a); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy_a !== 1'b0 || req_a !== 1'b0) begin failures++; $display("FAIL rstmid_idle: busy=%b req=%b expected 0 0", busy_a, req_a); end
   endtask

   task automatic test_start_busy();
      int b, d0, cyc;
      bit ok;
      lat = 1; root_child = {1'b1, 8'd8}; max_index = 7'd8;
      b = rec_n; d0 = done_n;
      pulse_start(0);
      repeat (5) @(negedge clk);
      root_child = {1'b0, 8'd90};
      pulse_start(0);
      root_child = {1'b1, 8'd8};
      wait_done(80, cyc, ok);
      checks++; if (ok !== 1'b1 || err_a !== 1'b0) begin failures++; $display("FAIL busy_done: done=%b err=%b expected 1 0", ok, err_a); end
      repeat (10) @(negedge clk);
      checks++; if (done_n - d0 !== 1 || busy_a !== 1'b0) begin failures++; $display("FAIL busy_one_walk: got %0d done pulses busy=%b expected 1 0", done_n - d0, busy_a); end
      checks++; if (rec_n - b !== 10) begin failures++; $display("FAIL busy_count: got %0d records expected 10", rec_n - b); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({24'd0, rec_sym[b+i]} !== EXP_SYM[i] || rec_code[b+i] !== EXP_CODE[i] || {26'd0, rec_len[b+i]} !== EXP_LEN[i]) begin
            failures++;
            $display("FAIL busy_rec%0d: got %0d/%0h/%0d expected %0d/%0h/%0d", i, rec_sym[b+i], rec_code[b+i], rec_len[b+i], EXP_SYM[i], EXP_CODE[i], EXP_LEN[i]);
         end
      end
   endtask

   initial begin
      init_mem();
      test_reset();
      test_base_walk();
      test_slow_fetch();
      test_backpressure();
      test_root_leaf();
      test_maxlen();
      test_bad_index();
      test_reset_mid();
      test_start_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
